// File: rtl/uart_loader.sv
// uart_loader: parses a framed program image from the UART receive stream
// (HDR, LEN_L, LEN_H, LEN x {lo, hi}, CSUM) and writes it word by word into
// instruction memory. The CPU is held in reset for the whole load.
module uart_loader #(
    parameter int          ADDR_W  = 10,
    parameter int          TIMEOUT = 27_000_000,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    // 17 bits so that a full 2**16-word image still compares correctly
    localparam logic [16:0]     MAX_LEN = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_L, S_LEN_H, S_DATA_L, S_DATA_H, S_CSUM
    } state_t;

    state_t          state;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [7:0]      lo_byte;
    logic [7:0]      acc;
    logic [15:0]     word_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     len_w;
    logic [7:0]      csum_w;

    assign len_w  = {rx_byte, len_lo};
    assign csum_w = acc + rx_byte;

    // Frame parser, write port, timeout and status flags
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            len       <= '0;
            lo_byte   <= '0;
            acc       <= '0;
            word_cnt  <= '0;
            to_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b1;
            loading   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            // address advances once the write pulse has been presented
            if (mem_we)
                mem_addr <= mem_addr + ADDR_W'(1);

            if (state == S_IDLE || rx_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);

            if (rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (rx_byte == HDR) begin
                            state     <= S_LEN_L;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            acc       <= '0;
                            word_cnt  <= '0;
                            mem_addr  <= '0;
                            cpu_rst_n <= 1'b0;
                            loading   <= 1'b1;
                        end
                    end
                    S_LEN_L: begin
                        len_lo <= rx_byte;
                        state  <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len <= len_w;
                        if ({1'b0, len_w} > MAX_LEN) begin
                            err       <= 1'b1;
                            state     <= S_IDLE;
                            cpu_rst_n <= 1'b1;
                            loading   <= 1'b0;
                        end else if (len_w == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA_L;
                        end
                    end
                    S_DATA_L: begin
                        lo_byte <= rx_byte;
                        acc     <= acc + rx_byte;
                        state   <= S_DATA_H;
                    end
                    S_DATA_H: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {rx_byte, lo_byte};
                        acc       <= acc + rx_byte;
                        word_cnt  <= word_cnt + 16'd1;
                        state     <= (word_cnt == len - 16'd1) ? S_CSUM : S_DATA_L;
                    end
                    S_CSUM: begin
                        if (csum_w == 8'h00) done <= 1'b1;
                        else                 err  <= 1'b1;
                        state     <= S_IDLE;
                        cpu_rst_n <= 1'b1;
                        loading   <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (state != S_IDLE && to_cnt == TO_LAST) begin
                // a byte arriving on this cycle would have won above
                err       <= 1'b1;
                state     <= S_IDLE;
                cpu_rst_n <= 1'b1;
                loading   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader (ADDR_W=4, TIMEOUT=100): directed vector table,
// hand sequences for timing corners, then random frames against a parser model.
module tb_uart_loader;

    localparam int         ADDR_W  = 4;
    localparam int         TIMEOUT = 100;
    localparam logic [7:0] HDR     = 8'hA5;

    logic              sys_clk;
    logic              rst_n;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              loading;
    logic              done;
    logic              err;

    uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .HDR(HDR)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .loading   (loading),
        .done      (done),
        .err       (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [15:0]       d;
    } wr_t;

    typedef struct {
        logic [7:0]  b [8];
        int          n;
        int          nw;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        ed;
        logic        ee;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    wr_t        wq[$];       // writes observed on the memory port
    wr_t        exp_w[$];    // writes predicted by the model
    logic       exp_d, exp_e;
    logic [7:0] stim_q[$];
    logic       prev_we = 1'b0;
    vec_t       vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record every write; a write pulse must never last two cycles
    always @(negedge sys_clk) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            chk("we_pulse", {31'd0, prev_we}, 32'd0);
        end
        prev_we = mem_we;
    end

    // Called at a negedge; strobes one byte, then idles for gap cycles
    task automatic send(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_stream(input int maxgap);
        foreach (stim_q[i]) send(stim_q[i], $urandom_range(0, maxgap));
    endtask

    // Reference parser: find the header, read the length, then walk the
    // payload as little-endian words and sum the bytes for the checksum.
    function automatic void model_frame();
        int          i = 0;
        int          ln;
        logic [7:0]  sum = 8'h00;
        exp_w.delete();
        while (stim_q[i] != HDR) i++;
        ln = {stim_q[i+2], stim_q[i+1]};
        i += 3;
        if (ln > (1 << ADDR_W)) begin
            exp_d = 1'b0;
            exp_e = 1'b1;
            return;
        end
        for (int k = 0; k < ln; k++) begin
            exp_w.push_back({ADDR_W'(k), stim_q[i+1], stim_q[i]});
            sum = sum + stim_q[i] + stim_q[i+1];
            i += 2;
        end
        exp_d = (8'(sum + stim_q[i]) == 8'h00);
        exp_e = !exp_d;
    endfunction

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, wq.size(), exp_w.size());
        for (int k = 0; k < exp_w.size() && k < wq.size(); k++) begin
            chk({tag, "_addr"}, 32'(wq[k].a), 32'(exp_w[k].a));
            chk({tag, "_data"}, 32'(wq[k].d), 32'(exp_w[k].d));
        end
    endtask

    task automatic chk_idle(input string tag, input logic ed, input logic ee);
        chk({tag, "_done"},    {31'd0, done},      {31'd0, ed});
        chk({tag, "_err"},     {31'd0, err},       {31'd0, ee});
        chk({tag, "_loading"}, {31'd0, loading},   32'd0);
        chk({tag, "_cpurst"},  {31'd0, cpu_rst_n}, 32'd1);
    endtask

    task automatic good_frame_q();
        // payload 34 12 78 56 sums to 0x14, so the closing byte is EC
        stim_q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC};
    endtask

    initial begin
        int         ln;
        int         nn;
        logic [7:0] b;
        logic [7:0] sum;

        vt[0] = '{b: '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC},
                  n: 8, nw: 2, d0: 16'h1234, d1: 16'h5678, ed: 1'b1, ee: 1'b0};
        vt[1] = '{b: '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hED},
                  n: 8, nw: 2, d0: 16'h1234, d1: 16'h5678, ed: 1'b0, ee: 1'b1};
        vt[2] = '{b: '{8'hA5, 8'h11, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00},
                  n: 5, nw: 0, d0: 16'h0, d1: 16'h0, ed: 1'b0, ee: 1'b1};
        vt[3] = '{b: '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                  n: 6, nw: 0, d0: 16'h0, d1: 16'h0, ed: 1'b1, ee: 1'b0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge sys_clk);
        chk("rst_we",    {31'd0, mem_we},  32'd0);
        chk("rst_addr",  32'(mem_addr),    32'd0);
        chk("rst_wdata", 32'(mem_wdata),   32'd0);
        chk_idle("rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge sys_clk);

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            wq.delete();
            for (int i = 0; i < vt[v].n; i++) send(vt[v].b[i], 1);
            repeat (2) @(negedge sys_clk);
            chk($sformatf("vec%0d_nwr", v), wq.size(), vt[v].nw);
            if (vt[v].nw == 2 && wq.size() == 2) begin
                chk($sformatf("vec%0d_w0", v), 32'(wq[0]), 32'({4'd0, vt[v].d0}));
                chk($sformatf("vec%0d_w1", v), 32'(wq[1]), 32'({4'd1, vt[v].d1}));
            end
            chk_idle($sformatf("vec%0d", v), vt[v].ed, vt[v].ee);
        end

        // Accepting a new header clears the sticky done from the zero-length frame
        send(8'hA5, 0);
        chk("hdr_clr_done",  {31'd0, done},      32'd0);
        chk("hdr_loading",   {31'd0, loading},   32'd1);
        chk("hdr_cpurst",    {31'd0, cpu_rst_n}, 32'd0);
        send(8'h00, 1); send(8'h00, 1); send(8'h00, 1);
        chk_idle("zero2", 1'b1, 1'b0);

        // Write latency, back-to-back bytes, cpu reset release timing
        wq.delete();
        send(8'hA5, 1); send(8'h02, 1); send(8'h00, 1); send(8'h34, 1);
        send(8'h12, 0);
        chk("lat_we0",   {31'd0, mem_we}, 32'd1);
        chk("lat_addr0", 32'(mem_addr),   32'd0);
        chk("lat_data0", 32'(mem_wdata),  32'h1234);
        @(negedge sys_clk);
        chk("lat_we_off", {31'd0, mem_we}, 32'd0);
        chk("lat_postinc", 32'(mem_addr),  32'd1);
        send(8'h78, 0);
        send(8'h56, 0);
        chk("lat_we1",   {31'd0, mem_we}, 32'd1);
        chk("lat_addr1", 32'(mem_addr),   32'd1);
        chk("lat_data1", 32'(mem_wdata),  32'h5678);
        chk("lat_cpurst_wr", {31'd0, cpu_rst_n}, 32'd0);
        send(8'hEC, 0);
        chk("lat_addr_end", 32'(mem_addr), 32'd2);
        chk_idle("lat", 1'b1, 1'b0);

        // Timeout: silence after the 34 strobe -> err exactly 100 cycles later
        send(8'hA5, 1); send(8'h01, 1); send(8'h00, 1); send(8'h34, 0);
        repeat (TIMEOUT - 1) @(negedge sys_clk);
        chk("to_not_yet", {31'd0, err},     32'd0);
        chk("to_loading", {31'd0, loading}, 32'd1);
        @(negedge sys_clk);
        chk_idle("to", 1'b0, 1'b1);

        // A strobe 99 cycles after the previous one keeps the frame alive
        wq.delete();
        send(8'hA5, 1); send(8'h01, 1); send(8'h00, 1); send(8'h34, 0);
        repeat (TIMEOUT - 2) @(negedge sys_clk);
        send(8'h12, 3);
        chk("alive_err", {31'd0, err}, 32'd0);
        send(8'hBA, 1);
        chk("alive_nwr", wq.size(), 1);
        chk_idle("alive", 1'b1, 1'b0);

        // Asynchronous reset mid-frame, then a clean reload from address 0
        send(8'hA5, 1); send(8'h02, 1); send(8'h00, 1); send(8'h34, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_we",    {31'd0, mem_we}, 32'd0);
        chk("mrst_addr",  32'(mem_addr),   32'd0);
        chk("mrst_wdata", 32'(mem_wdata),  32'd0);
        chk_idle("mrst", 1'b0, 1'b0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        wq.delete();
        good_frame_q();
        model_frame();
        send_stream(2);
        repeat (2) @(negedge sys_clk);
        chk_writes("reload");
        chk_idle("reload", exp_d, exp_e);

        // Random frames: noise, lengths incl. 16 (address wrap) and overflow, gaps 0..3
        for (int f = 0; f < 40; f++) begin
            stim_q.delete();
            wq.delete();
            nn = $urandom_range(0, 2);
            repeat (nn) begin
                do b = 8'($urandom); while (b == HDR);
                stim_q.push_back(b);
            end
            stim_q.push_back(HDR);
            if (f == 1)                         ln = 16;
            else if (f == 2)                    ln = 17;
            else if ($urandom_range(0, 7) == 0) ln = $urandom_range(17, 600);
            else                                ln = $urandom_range(0, 16);
            stim_q.push_back(8'(ln));
            stim_q.push_back(8'(ln >> 8));
            if (ln <= 16) begin
                sum = 8'h00;
                repeat (2 * ln) begin
                    b = 8'($urandom);
                    sum = sum + b;
                    stim_q.push_back(b);
                end
                b = 8'h00 - sum;
                if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
                stim_q.push_back(b);
            end
            model_frame();
            send_stream(3);
            repeat (3) @(negedge sys_clk);
            chk_writes($sformatf("rnd%0d", f));
            chk_idle($sformatf("rnd%0d", f), exp_d, exp_e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
